instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Fetch-side master of the combinational 16-bit instruction ROM.
- Owns the program counter (PC) and drives the ROM address; the ROM returns the instruction in the same cycle.
- Queues each {pc+1, instr} pair in a small prefetch FIFO and presents it to decode over a valid/ready handshake.
- Accepts PC redirects (taken bz, pc = pc+1+off6 computed downstream) and flushes the FIFO on each one.

Parameters:
- DEPTH, 2, prefetch FIFO entries; power of 2, minimum 2.
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- imem_addr  out  16  ROM address; equals the PC register.
- imem_data  in  16  ROM instruction for imem_addr, same cycle.
- redirect_valid  in  1  taken branch or jump this cycle.
- redirect_pc  in  16  new PC, sampled when redirect_valid=1.
- out_valid  out  1  FIFO head holds a valid instruction.
- out_ready  in  1  decode accepts the head this cycle.
- out_instr  out  16  instruction at the FIFO head; 0 when empty.
- out_pc_next  out  16  fetch address + 1 for the head entry (branch base for decode).
- halted  out  1  fetch stopped by the halt instruction (macro only; tied 0 otherwise).

Behaviour:
- Reset (rst=0, asynchronous):
  - PC=RESET_PC, FIFO empty (count=0, read/write pointers 0).
  - out_valid=0, out_instr=0, out_pc_next=0, halted=0.
- pop = out_valid & out_ready.
- fetch = !redirect_valid & !halted & (count<DEPTH | pop).
- On fetch:
  - Write entry {imem_addr+1, imem_data} at the write pointer.
  - PC <= PC+1, modulo 2^16 (16'hFFFF -> 16'h0000; stored pc_next also wraps to 0).
- On pop: advance the read pointer.
- count update:
  - count += fetch - pop.
  - Simultaneous fetch and pop on a full FIFO: count stays DEPTH; no overflow, no lost entry.
- Redirect has priority over everything else in the cycle:
  - FIFO cleared, count=0.
  - PC <= redirect_pc; halted cleared.
  - No write that cycle.
  - A pop in the same cycle is legal and consumed; its entry is discarded by the flush anyway.
- Latency:
  - The first instruction is valid the cycle after reset deasserts (fetched in cycle 0, visible in cycle 1).
  - After a redirect in cycle N: out_valid=0 in N+1; the target instruction is valid in N+2.
- Throughput: 1 instruction per cycle while out_ready=1.
- Backpressure (out_ready=0):
  - Fetches continue until count=DEPTH, then the PC freezes.
  - Head outputs hold stable while out_valid=1 and out_ready=0.
- Head outputs are driven from FIFO storage; no combinational path from imem_data to out_*.
- Pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.

Optional Feature:
- Macro: FETCH_HALT_ON_ZERO_EN.
- Defined:
  - When imem_data==16'h0000 (the ROM default for unprogrammed addresses) and fetch=1, the zero word is not enqueued.
  - PC does not advance; halted<=1 next cycle.
  - While halted: no fetch. The FIFO still drains normally.
  - Only a redirect or reset clears halted.
- Not defined:
  - 16'h0000 is enqueued as an ordinary instruction.
  - halted is constant 0.

Test Plan:
- Reset release with out_ready=1, ROM program loaded: cycles 1,2,3 show out_instr 0xB683, 0x1E80, 0x6C88 with out_pc_next 1, 2, 3; out_valid steady 1.
- Backpressure, DEPTH=2, out_ready=0 from reset for 5 cycles: imem_addr stops at 2; out_instr holds 0xB683, out_pc_next=1. Then out_ready=1: entries 1, 2, 3 follow with no gap and no duplicate.
- Redirect: redirect_valid=1 with redirect_pc=5 while fetching at pc 10 (bz offset -6 → 5). Required: out_valid=0 next cycle, then out_instr=0x5B18 (pc 6 entry follows), with out_pc_next=6; stale entries never appear.
- Simultaneous pop and fetch at full (DEPTH=2, out_ready toggling 1/0): count never exceeds 2; every pc from 0 to 10 is delivered exactly once, in order.
- Wrap: redirect_pc=16'hFFFF. Head entry has out_pc_next=16'h0000 and the next imem_addr is 16'h0000.
- Halt (macro on): run to pc 11 (ROM returns 0). halted=1 and imem_addr holds 11; pc 10 is still delivered. Then redirect_pc=0: halted=0 and 0xB683 is delivered again. With the macro off, the 0x0000 word is delivered with out_pc_next=12.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Fetch-side master of the 16-bit instruction ROM: owns the PC and queues {pc+1, instr} pairs in a prefetch FIFO.
// Optional halt-on-zero fetch stop is enabled with FETCH_HALT_ON_ZERO_EN.
module instr_fetch_unit #(
    parameter int          DEPTH    = 2,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_instr,
    output logic [15:0] out_pc_next,
    output logic        halted
);

    localparam int            PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int            CW   = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [15:0]   pc_q;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          halted_q;
    logic [15:0]   instr_mem [DEPTH];
    logic [15:0]   pcn_mem   [DEPTH];

    logic pop;
    logic fetch;
    logic enq;
    logic halt_hit;

    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    assign fetch     = !redirect_valid & !halted_q & ((count < FULL) | pop);

`ifdef FETCH_HALT_ON_ZERO_EN
    // An unprogrammed ROM word stops fetch instead of being queued.
    assign halt_hit = fetch & (imem_data == 16'h0000);
`else
    assign halt_hit = 1'b0;
`endif

    assign enq = fetch & !halt_hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q     <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            halted_q <= 1'b0;
        end else if (redirect_valid) begin
            // Flush wins over any fetch or pop in the same cycle.
            pc_q     <= redirect_pc;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            halted_q <= 1'b0;
        end else begin
            if (enq) begin
                pc_q   <= pc_q + 16'd1;
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(enq) - CW'(pop);
            if (halt_hit) begin
                halted_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            instr_mem[wr_ptr] <= imem_data;
            pcn_mem[wr_ptr]   <= pc_q + 16'd1;
        end
    end

    assign imem_addr   = pc_q;
    assign out_instr   = out_valid ? instr_mem[rd_ptr] : 16'h0000;
    assign out_pc_next = out_valid ? pcn_mem[rd_ptr] : 16'h0000;
    assign halted      = halted_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: stimulus queues expected {pc_next, instr} pairs, a negedge monitor checks each pop.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_instr;
    logic [15:0] out_pc_next;
    logic        halted;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    function automatic logic [15:0] rom(input logic [15:0] a);
        case (a)
            16'd0:    rom = 16'hB683;
            16'd1:    rom = 16'h1E80;
            16'd2:    rom = 16'h6C88;
            16'd3:    rom = 16'h2A41;
            16'd4:    rom = 16'h3C52;
            16'd5:    rom = 16'h5B18;
            16'd6:    rom = 16'h4D63;
            16'd7:    rom = 16'h6E74;
            16'd8:    rom = 16'h7F85;
            16'd9:    rom = 16'h8096;
            16'd10:   rom = 16'h91A7;
            16'hFFFF: rom = 16'hC0DE;
            default:  rom = 16'h0000;
        endcase
    endfunction

    function automatic logic [31:0] mk(input logic [15:0] pc);
        logic [15:0] pn;
        pn = pc + 16'd1;
        mk = {pn, rom(pc)};
    endfunction

    assign imem_data = rom(imem_addr);

    instr_fetch_unit #(.DEPTH(2), .RESET_PC(16'h0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc_next    (out_pc_next),
        .halted         (halted)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_range(input int lo, input int hi);
        for (int p = lo; p <= hi; p++) exp_q.push_back(mk(16'(p)));
    endtask

    task automatic drain(input bit toggle);
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
            if (toggle) out_ready = ~out_ready;
            tick();
        end
        chk("drain_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic start(input logic rdy);
        rst = 1'b0;
        redirect_valid = 1'b0;
        out_ready = rdy;
        tick();
    endtask

    // Monitor: every accepted head entry must match the next expected pair.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pop", {out_pc_next, out_instr}, 32'hxxxxxxxx);
                end else begin
                    e = exp_q.pop_front();
                    chk("pop_entry", {out_pc_next, out_instr}, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state and first-instruction latency
        start(1'b1);
        tick();
        #2;
        chk("rst_addr", 32'(imem_addr), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_instr", 32'(out_instr), 32'h0);
        chk("rst_pcn", 32'(out_pc_next), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        tick();
        push_range(0, 2);
        rst = 1'b1;
        #2;
        chk("c0_valid", 32'(out_valid), 32'h0);
        tick();
        for (int c = 1; c <= 3; c++) begin
            #2;
            chk("stream_valid", 32'(out_valid), 32'h1);
            tick();
        end
        drain(1'b0);

        // Backpressure from reset
        start(1'b0);
        rst = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            #2;
            chk("bp_addr", 32'(imem_addr), (c >= 2) ? 32'd2 : 32'(c));
            chk("bp_instr", 32'(out_instr), 32'hB683);
            chk("bp_pcn", 32'(out_pc_next), 32'h1);
        end
        push_range(0, 3);
        out_ready = 1'b1;
        drain(1'b0);

        // Redirect while fetching pc 10
        start(1'b1);
        push_range(0, 9);
        rst = 1'b1;
        repeat (10) tick();
        #2;
        chk("redir_addr", 32'(imem_addr), 32'd10);
        redirect_valid = 1'b1;
        redirect_pc = 16'd5;
        push_range(5, 6);
        tick();
        redirect_valid = 1'b0;
        #2;
        chk("redir_bubble", 32'(out_valid), 32'h0);
        tick();
        #2;
        chk("redir_target", {out_pc_next, out_instr}, {16'd6, 16'h5B18});
        drain(1'b0);

        // Toggling ready: pop and fetch together at full
        start(1'b1);
        push_range(0, 10);
        rst = 1'b1;
        drain(1'b1);

        // PC wrap
        start(1'b1);
        rst = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 16'hFFFF;
        exp_q.push_back(mk(16'hFFFF));
        exp_q.push_back(mk(16'h0000));
        tick();
        redirect_valid = 1'b0;
        #2;
        chk("wrap_bubble", 32'(out_valid), 32'h0);
        chk("wrap_addr_ffff", 32'(imem_addr), 32'hFFFF);
        tick();
        #2;
        chk("wrap_addr_0", 32'(imem_addr), 32'h0);
        chk("wrap_pcn", 32'(out_pc_next), 32'h0);
        drain(1'b0);

        // Zero word at pc 11
        start(1'b1);
`ifdef FETCH_HALT_ON_ZERO_EN
        push_range(0, 10);
`else
        push_range(0, 11);
`endif
        rst = 1'b1;
        repeat (12) tick();
        #2;
`ifdef FETCH_HALT_ON_ZERO_EN
        chk("halt_set", 32'(halted), 32'h1);
        chk("halt_addr", 32'(imem_addr), 32'd11);
        chk("halt_empty", 32'(out_valid), 32'h0);
        repeat (2) tick();
        #2;
        chk("halt_hold_addr", 32'(imem_addr), 32'd11);
        chk("halt_hold", 32'(halted), 32'h1);
        redirect_valid = 1'b1;
        redirect_pc = 16'd0;
        push_range(0, 1);
        tick();
        redirect_valid = 1'b0;
        #2;
        chk("halt_clear", 32'(halted), 32'h0);
`else
        chk("nohalt", 32'(halted), 32'h0);
        chk("zero_word", {out_pc_next, out_instr}, {16'd12, 16'h0000});
`endif
        drain(1'b0);

        rst = 1'b0;
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
